// File: rtl/flash_sram_loader_if.sv
// ---------------------------------------------------------------------------
// flash_sram_loader_if
// Bundles the control handshake and the flash/SRAM pin-side buses of the
// boot-copy engine.
//   slave  : the loader itself (takes requests, drives flash/SRAM pins)
//   master : the boot/control logic (issues requests, supplies flash data)
// Control   : start, abort, src_addr, dst_bank, dst_addr, len_words, swap
// Status    : busy, done, error, aborted, words_done
// Flash     : flash_a, flash_d_i, flash_ce_n, flash_oe_n
// SRAM      : sram_addr, sram_d_o, sram_d_oe, sram_ce_n, sram_we_n, sram_be_n
// ---------------------------------------------------------------------------
interface flash_sram_loader_if #(
    parameter int ADDR_W       = 20,
    parameter int FLASH_ADDR_W = 23,
    parameter int NUM_BANKS    = 2
);
    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    logic                    start;
    logic                    abort;
    logic [FLASH_ADDR_W-1:0] src_addr;
    logic [BANK_W-1:0]       dst_bank;
    logic [ADDR_W-1:0]       dst_addr;
    logic [ADDR_W:0]         len_words;
    logic                    swap;

    logic                    busy;
    logic                    done;
    logic                    error;
    logic                    aborted;
    logic [ADDR_W:0]         words_done;

    logic [FLASH_ADDR_W-1:0] flash_a;
    logic [15:0]             flash_d_i;
    logic                    flash_ce_n;
    logic                    flash_oe_n;

    logic [ADDR_W-1:0]       sram_addr;
    logic [31:0]             sram_d_o;
    logic                    sram_d_oe;
    logic [NUM_BANKS-1:0]    sram_ce_n;
    logic                    sram_we_n;
    logic [3:0]              sram_be_n;

    modport slave (
        input  start, abort, src_addr, dst_bank, dst_addr, len_words, swap, flash_d_i,
        output busy, done, error, aborted, words_done,
        output flash_a, flash_ce_n, flash_oe_n,
        output sram_addr, sram_d_o, sram_d_oe, sram_ce_n, sram_we_n, sram_be_n
    );

    modport master (
        output start, abort, src_addr, dst_bank, dst_addr, len_words, swap, flash_d_i,
        input  busy, done, error, aborted, words_done,
        input  flash_a, flash_ce_n, flash_oe_n,
        input  sram_addr, sram_d_o, sram_d_oe, sram_ce_n, sram_we_n, sram_be_n
    );
endinterface

// File: rtl/flash_sram_loader.sv
// ---------------------------------------------------------------------------
// flash_sram_loader
// Boot-copy engine: reads 16-bit halfwords from parallel NOR flash, assembles
// them into 32-bit words (optionally byte-reversed) and writes them into one
// of NUM_BANKS SRAM banks. Owns the flash/SRAM buses only while busy.
// Ports:
//   clk   : single clock
//   rst_n : asynchronous active-low reset
//   bus   : flash_sram_loader_if.slave (request/status + flash/SRAM pins)
// ---------------------------------------------------------------------------
module flash_sram_loader #(
    parameter int ADDR_W       = 20,
    parameter int FLASH_ADDR_W = 23,
    parameter int NUM_BANKS    = 2,
    parameter int FLASH_WAIT   = 4,
    parameter int WE_CYCLES    = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    flash_sram_loader_if.slave  bus
);
    localparam int BANK_W  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int CNT_MAX = (FLASH_WAIT > WE_CYCLES) ? FLASH_WAIT : WE_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    // 2^ADDR_W expressed in the width used for the end-of-range sum
    localparam logic [ADDR_W+1:0] SRAM_WORDS = {2'b01, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {
        IDLE, CHECK, RD_LO, RD_HI, WR_SETUP, WR_PULSE, WR_HOLD, FIN
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [FLASH_ADDR_W-1:0] src_q, src_d;
    logic [BANK_W-1:0]       bank_q, bank_d;
    logic [ADDR_W-1:0]       dst_q, dst_d;
    logic [ADDR_W:0]         len_q, len_d;
    logic                    swap_q, swap_d;
    logic [15:0]             lo_q, lo_d;
    logic [31:0]             word_q, word_d;
    logic [ADDR_W:0]         wdone_q, wdone_d;
    logic                    err_q, err_d;
    logic                    abt_q, abt_d;

    function automatic logic [31:0] byte_rev(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    logic              bank_bad;
    logic              range_bad;
    logic [ADDR_W+1:0] end_addr;
    logic [ADDR_W:0]   wdone_inc;

    always_comb begin
        bank_bad  = (32'(bank_q) >= 32'(NUM_BANKS));
        end_addr  = {2'b00, dst_q} + {1'b0, len_q};
        range_bad = (end_addr > SRAM_WORDS);
        wdone_inc = wdone_q + (ADDR_W+1)'(1);
    end

    // State register and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            src_q   <= '0;
            bank_q  <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            swap_q  <= 1'b0;
            lo_q    <= '0;
            word_q  <= '0;
            wdone_q <= '0;
            err_q   <= 1'b0;
            abt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            src_q   <= src_d;
            bank_q  <= bank_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            swap_q  <= swap_d;
            lo_q    <= lo_d;
            word_q  <= word_d;
            wdone_q <= wdone_d;
            err_q   <= err_d;
            abt_q   <= abt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        src_d   = src_q;
        bank_d  = bank_q;
        dst_d   = dst_q;
        len_d   = len_q;
        swap_d  = swap_q;
        lo_d    = lo_q;
        word_d  = word_q;
        wdone_d = wdone_q;
        err_d   = err_q;
        abt_d   = abt_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    src_d   = bus.src_addr;
                    bank_d  = bus.dst_bank;
                    dst_d   = bus.dst_addr;
                    len_d   = bus.len_words;
                    swap_d  = bus.swap;
                    wdone_d = '0;
                    err_d   = 1'b0;
                    abt_d   = 1'b0;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                cnt_d = '0;
                if (src_q[0] || bank_bad || range_bad) begin
                    err_d   = 1'b1;
                    state_d = FIN;
                end else if (len_q == '0) begin
                    state_d = FIN;
                end else begin
                    state_d = RD_LO;
                end
            end
            RD_LO: begin
                // Data is only guaranteed valid after the full access time
                if (cnt_q == CNT_W'(FLASH_WAIT - 1)) begin
                    lo_d    = bus.flash_d_i;
                    cnt_d   = '0;
                    state_d = RD_HI;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RD_HI: begin
                if (cnt_q == CNT_W'(FLASH_WAIT - 1)) begin
                    word_d  = swap_q ? byte_rev({bus.flash_d_i, lo_q})
                                     : {bus.flash_d_i, lo_q};
                    cnt_d   = '0;
                    state_d = WR_SETUP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WR_SETUP: begin
                cnt_d   = '0;
                state_d = WR_PULSE;
            end
            WR_PULSE: begin
                if (cnt_q == CNT_W'(WE_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = WR_HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WR_HOLD: begin
                wdone_d = wdone_inc;
                src_d   = src_q + FLASH_ADDR_W'(4);
                dst_d   = dst_q + ADDR_W'(1);
                cnt_d   = '0;
                // Completion takes priority over abort on the final word
                if (wdone_inc == len_q) begin
                    state_d = FIN;
                end else if (bus.abort) begin
                    abt_d   = 1'b1;
                    state_d = FIN;
                end else begin
                    state_d = RD_LO;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode straight from the state register so reset releases
    // every strobe immediately, including mid write pulse.
    always_comb begin
        bus.busy       = (state_q != IDLE);
        bus.done       = (state_q == FIN);
        bus.error      = (state_q == FIN) && err_q;
        bus.aborted    = (state_q == FIN) && abt_q;
        bus.words_done = wdone_q;

        bus.flash_a    = '0;
        bus.flash_ce_n = 1'b1;
        bus.flash_oe_n = 1'b1;
        bus.sram_addr  = '0;
        bus.sram_d_o   = '0;
        bus.sram_d_oe  = 1'b0;
        bus.sram_ce_n  = '1;
        bus.sram_we_n  = 1'b1;
        bus.sram_be_n  = 4'hF;

        case (state_q)
            RD_LO: begin
                bus.flash_a    = src_q;
                bus.flash_ce_n = 1'b0;
                bus.flash_oe_n = 1'b0;
            end
            RD_HI: begin
                bus.flash_a    = src_q + FLASH_ADDR_W'(2);
                bus.flash_ce_n = 1'b0;
                bus.flash_oe_n = 1'b0;
            end
            WR_SETUP, WR_PULSE, WR_HOLD: begin
                bus.sram_addr = dst_q;
                bus.sram_d_o  = word_q;
                bus.sram_d_oe = 1'b1;
                bus.sram_be_n = 4'h0;
                for (int b = 0; b < NUM_BANKS; b++) begin
                    if (32'(bank_q) == 32'(b)) begin
                        bus.sram_ce_n[b] = 1'b0;
                    end
                end
                bus.sram_we_n = (state_q != WR_PULSE);
            end
            default: begin
            end
        endcase
    end
endmodule
